// File: rtl/dcache_miss_engine.sv
// Blocking data-cache miss handler: sequences victim write-back, block fill and
// write-around traffic between the pipeline, the cache array and memory.
//
// state       | meaning
// IDLE        | serve hits, detect misses and latch the request
// WRITEBACK   | write the dirty victim block to memory
// MEMREAD     | fetch the missing block from memory
// FILL        | write the fetched (and merged) block into the cache array
// WRITEAROUND | write the store straight to memory, no allocation
// RESUME      | one-cycle release of the pipeline after a write-around
module dcache_miss_engine #(
    parameter int ADDR_W         = 32,
    parameter int WORD_BYTES     = 4,
    parameter int BLOCK_BYTES    = 32,
    parameter int WRITE_ALLOCATE = 1,
    parameter int TIMEOUT        = 255,
    parameter int CNT_W          = 16,
    localparam int OFF_W = $clog2(BLOCK_BYTES),
    localparam int WB_W  = $clog2(WORD_BYTES),
    localparam int BA_W  = ADDR_W - OFF_W,
    localparam int WBITS = 8 * WORD_BYTES,
    localparam int BBITS = 8 * BLOCK_BYTES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ren,
    input  logic                   wen,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WORD_BYTES-1:0]  byteSelectVector,
    input  logic [WBITS-1:0]       din,
    input  logic                   cacheHit,
    input  logic                   cacheDirtyBit,
    input  logic [BBITS-1:0]       cacheDout,
    input  logic [BA_W-1:0]        cacheVictimBlockAddr,
    input  logic                   memReadReady,
    input  logic                   memWriteDone,
    input  logic [BBITS-1:0]       memDout,
    output logic                   stall,
    output logic [WBITS-1:0]       dout,
    output logic [BA_W-1:0]        BlockAddr,
    output logic                   cacheRen,
    output logic                   cacheWen,
    output logic                   cacheMemWen,
    output logic [BLOCK_BYTES-1:0] cacheBytesAccess,
    output logic [BBITS-1:0]       cacheDin,
    output logic [BA_W-1:0]        memBlockAddr,
    output logic                   memRen,
    output logic                   memWen,
    output logic [BLOCK_BYTES-1:0] memByteEn,
    output logic [BBITS-1:0]       memDin,
    output logic                   memError,
    output logic [CNT_W-1:0]       missCount
);

    localparam int WPB   = BLOCK_BYTES / WORD_BYTES;
    localparam int WI_W  = OFF_W - WB_W;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_TC = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WRITEBACK   = 3'd1;
    localparam logic [2:0] S_MEMREAD     = 3'd2;
    localparam logic [2:0] S_FILL        = 3'd3;
    localparam logic [2:0] S_WRITEAROUND = 3'd4;
    localparam logic [2:0] S_RESUME      = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [TMR_W-1:0]      wait_cnt;
    logic [BA_W-1:0]       lat_baddr;
    logic [BA_W-1:0]       lat_victim;
    logic [WI_W-1:0]       lat_widx;
    logic [WBITS-1:0]      lat_din;
    logic [WORD_BYTES-1:0] lat_bsv;
    logic                  lat_write;
    logic [BBITS-1:0]      fill_data;

    logic                   is_idle;
    logic                   valid_req;
    logic                   req_write;
    logic                   miss;
    logic                   waiting;
    logic                   handshake;
    logic                   timeout_hit;
    logic [WI_W-1:0]        cur_widx;
    logic [WORD_BYTES-1:0]  cur_bsv;
    logic [WBITS-1:0]       cur_din;
    logic [BLOCK_BYTES-1:0] slot_be;
    logic [BBITS-1:0]       din_rep;
    logic [BBITS-1:0]       fill_merged;

    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[WB_W-1:0];

    assign is_idle   = (state == S_IDLE);
    assign valid_req = ren ^ wen;
    assign req_write = wen & ~ren;
    assign miss      = is_idle & valid_req & ~cacheHit;

    assign waiting   = (state == S_WRITEBACK) || (state == S_MEMREAD) ||
                       (state == S_WRITEAROUND);
    assign handshake = (((state == S_WRITEBACK) || (state == S_WRITEAROUND)) && memWriteDone) ||
                       ((state == S_MEMREAD) && memReadReady);
    assign timeout_hit = (TIMEOUT != 0) && waiting && !handshake && (wait_cnt == TMR_TC);

    // Outside IDLE the pipeline fields are stale; everything steers off the latched copy.
    assign cur_widx = is_idle ? addr[OFF_W-1:WB_W] : lat_widx;
    assign cur_bsv  = is_idle ? byteSelectVector   : lat_bsv;
    assign cur_din  = is_idle ? din                : lat_din;
    assign din_rep  = {WPB{cur_din}};
    assign dout     = cacheDout[cur_widx*WBITS +: WBITS];

    always_comb begin
        slot_be = '0;
        for (int w = 0; w < WPB; w++) begin
            if (cur_widx == WI_W'(w)) begin
                slot_be[w*WORD_BYTES +: WORD_BYTES] = cur_bsv;
            end
        end
    end

    always_comb begin
        fill_merged = fill_data;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (lat_write && slot_be[b]) begin
                fill_merged[b*8 +: 8] = din_rep[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (miss) begin
                    if (req_write && (WRITE_ALLOCATE == 0)) state_nx = S_WRITEAROUND;
                    else if (cacheDirtyBit)                 state_nx = S_WRITEBACK;
                    else                                    state_nx = S_MEMREAD;
                end
            end
            S_WRITEBACK: begin
                if (memWriteDone)     state_nx = S_MEMREAD;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_MEMREAD: begin
                if (memReadReady)     state_nx = S_FILL;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_FILL:   state_nx = S_IDLE;
            S_WRITEAROUND: begin
                if (memWriteDone)     state_nx = S_RESUME;
                else if (timeout_hit) state_nx = S_IDLE;
            end
            S_RESUME: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stall            = 1'b0;
        cacheRen         = 1'b0;
        cacheWen         = 1'b0;
        cacheMemWen      = 1'b0;
        BlockAddr        = is_idle ? addr[ADDR_W-1:OFF_W] : lat_baddr;
        cacheBytesAccess = slot_be;
        cacheDin         = din_rep;
        memBlockAddr     = lat_baddr;
        memRen           = 1'b0;
        memWen           = 1'b0;
        memByteEn        = '0;
        memDin           = '0;
        case (state)
            S_IDLE: begin
                stall    = miss;
                cacheRen = valid_req & ~req_write & cacheHit;
                cacheWen = valid_req & req_write & cacheHit;
            end
            S_WRITEBACK: begin
                stall        = 1'b1;
                memWen       = 1'b1;
                memBlockAddr = lat_victim;
                memDin       = cacheDout;
                memByteEn    = '1;
            end
            S_MEMREAD: begin
                stall  = 1'b1;
                memRen = 1'b1;
            end
            S_FILL: begin
                stall            = 1'b1;
                cacheMemWen      = 1'b1;
                cacheBytesAccess = '1;
                cacheDin         = fill_merged;
            end
            S_WRITEAROUND: begin
                stall     = 1'b1;
                memWen    = 1'b1;
                memDin    = din_rep;
                memByteEn = slot_be;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            memError   <= 1'b0;
            missCount  <= '0;
            lat_baddr  <= '0;
            lat_victim <= '0;
            lat_widx   <= '0;
            lat_din    <= '0;
            lat_bsv    <= '0;
            lat_write  <= 1'b0;
            fill_data  <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (waiting && (TIMEOUT != 0)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                memError <= 1'b1;
            end
            if (miss) begin
                lat_baddr  <= addr[ADDR_W-1:OFF_W];
                lat_victim <= cacheVictimBlockAddr;
                lat_widx   <= addr[OFF_W-1:WB_W];
                lat_din    <= din;
                lat_bsv    <= byteSelectVector;
                lat_write  <= req_write;
                if (missCount != '1) begin
                    missCount <= missCount + 1'b1;
                end
            end
            if ((state == S_MEMREAD) && memReadReady) begin
                fill_data <= memDout;
            end
        end
    end

endmodule

// File: tb/tb_dcache_miss_engine.sv
// Directed bench for dcache_miss_engine: a default instance plus a
// write-around / short-timeout instance sharing the same stimulus.
module tb_dcache_miss_engine;

    localparam int BA_W  = 27;
    localparam int WBITS = 32;
    localparam int BBITS = 256;
    localparam int NB    = 32;
    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             ren;
    logic             wen;
    logic [31:0]      addr;
    logic [3:0]       bsv;
    logic [WBITS-1:0] din;
    logic             hit;
    logic             dirty;
    logic [BBITS-1:0] cdout;
    logic [BA_W-1:0]  victim;
    logic             mrr;
    logic             mwd;
    logic [BBITS-1:0] mdout;

    logic             stall_0, stall_1;
    logic [WBITS-1:0] dout_0, dout_1;
    logic [BA_W-1:0]  baddr_0, baddr_1;
    logic             cren_0, cren_1;
    logic             cwen_0, cwen_1;
    logic             cmwen_0, cmwen_1;
    logic [NB-1:0]    cba_0, cba_1;
    logic [BBITS-1:0] cdin_0, cdin_1;
    logic [BA_W-1:0]  mba_0, mba_1;
    logic             mren_0, mren_1;
    logic             mwen_0, mwen_1;
    logic [NB-1:0]    mbe_0, mbe_1;
    logic [BBITS-1:0] mdin_0, mdin_1;
    logic             merr_0, merr_1;
    logic [CNT_W-1:0] mcnt_0, mcnt_1;

    logic [BBITS-1:0] cache_line;
    logic [BBITS-1:0] mem_line;
    logic [BBITS-1:0] exp_merge;
    int checks;
    int errors;

    dcache_miss_engine dut0 (
        .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
        .byteSelectVector(bsv), .din(din), .cacheHit(hit), .cacheDirtyBit(dirty),
        .cacheDout(cdout), .cacheVictimBlockAddr(victim), .memReadReady(mrr),
        .memWriteDone(mwd), .memDout(mdout), .stall(stall_0), .dout(dout_0),
        .BlockAddr(baddr_0), .cacheRen(cren_0), .cacheWen(cwen_0),
        .cacheMemWen(cmwen_0), .cacheBytesAccess(cba_0), .cacheDin(cdin_0),
        .memBlockAddr(mba_0), .memRen(mren_0), .memWen(mwen_0), .memByteEn(mbe_0),
        .memDin(mdin_0), .memError(merr_0), .missCount(mcnt_0)
    );

    dcache_miss_engine #(.WRITE_ALLOCATE(0), .TIMEOUT(4)) dut1 (
        .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
        .byteSelectVector(bsv), .din(din), .cacheHit(hit), .cacheDirtyBit(dirty),
        .cacheDout(cdout), .cacheVictimBlockAddr(victim), .memReadReady(mrr),
        .memWriteDone(mwd), .memDout(mdout), .stall(stall_1), .dout(dout_1),
        .BlockAddr(baddr_1), .cacheRen(cren_1), .cacheWen(cwen_1),
        .cacheMemWen(cmwen_1), .cacheBytesAccess(cba_1), .cacheDin(cdin_1),
        .memBlockAddr(mba_1), .memRen(mren_1), .memWen(mwen_1), .memByteEn(mbe_1),
        .memDin(mdin_1), .memError(merr_1), .missCount(mcnt_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [BBITS-1:0] obs, input logic [BBITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 8; k++) begin
            cache_line[k*32 +: 32] = 32'hC000_0000 + 32'(k);
            mem_line[k*32 +: 32]   = 32'hD000_0000 + 32'(k);
        end
        ren = 0; wen = 0; addr = 0; bsv = 0; din = 0; hit = 0; dirty = 0;
        cdout = cache_line; victim = 0; mrr = 0; mwd = 0; mdout = mem_line;
        reset = 0;
        step;
        step;
        #1;
        chk("rst_stall", stall_0, 0);
        chk("rst_misscount", mcnt_0, 0);
        chk("rst_memerror", merr_0, 0);
        chk("rst_memwen", mwen_0, 0);
        chk("rst_memren", mren_0, 0);
        chk("rst_cachememwen", cmwen_0, 0);
        reset = 1;

        // read hit, word 1 of block 1
        ren = 1; addr = 32'h24; hit = 1; bsv = 4'hF; din = 32'h1234_5678;
        #1;
        chk("hit_cacheren", cren_0, 1);
        chk("hit_cachewen", cwen_0, 0);
        chk("hit_stall", stall_0, 0);
        chk("hit_dout", dout_0, 32'hC000_0001);
        chk("hit_blockaddr", baddr_0, 1);
        chk("hit_bytesaccess", cba_0, 32'h0000_00F0);
        chk("hit_cachedin", cdin_0, {8{32'h1234_5678}});
        step;
        ren = 0;
        #1;
        chk("hit_misscount", mcnt_0, 0);

        // clean read miss, ready on third MEMREAD cycle
        ren = 1; addr = 32'h24; hit = 0; dirty = 0;
        #1;
        chk("rm_idle_stall", stall_0, 1);
        chk("rm_idle_cacheren", cren_0, 0);
        chk("rm_idle_memren", mren_0, 0);
        step;
        addr = 32'h1E0;
        #1;
        chk("rm_mr1_memren", mren_0, 1);
        chk("rm_mr1_stall", stall_0, 1);
        chk("rm_mr1_memblockaddr", mba_0, 1);
        chk("rm_mr1_misscount", mcnt_0, 1);
        step;
        #1;
        chk("rm_mr2_memren", mren_0, 1);
        chk("rm_mr2_stall", stall_0, 1);
        step;
        mrr = 1;
        #1;
        chk("rm_mr3_memren", mren_0, 1);
        chk("rm_mr3_stall", stall_0, 1);
        step;
        mrr = 0; mdout = ~mem_line;
        #1;
        chk("rm_fill_cachememwen", cmwen_0, 1);
        chk("rm_fill_stall", stall_0, 1);
        chk("rm_fill_blockaddr", baddr_0, 1);
        chk("rm_fill_bytesaccess", cba_0, 32'hFFFF_FFFF);
        chk("rm_fill_cachedin", cdin_0, mem_line);
        chk("rm_fill_memren", mren_0, 0);
        step;
        mdout = mem_line; addr = 32'h24; hit = 1;
        #1;
        chk("rm_replay_cachememwen", cmwen_0, 0);
        chk("rm_replay_stall", stall_0, 0);
        chk("rm_replay_cacheren", cren_0, 1);
        chk("rm_replay_dout", dout_0, 32'hC000_0001);
        step;
        ren = 0;
        #1;
        chk("rm_misscount", mcnt_0, 1);

        // dirty write miss, word 2 of block 2, low two bytes
        wen = 1; addr = 32'h48; din = 32'hAABB_CCDD; bsv = 4'b0011;
        hit = 0; dirty = 1; victim = 27'h155;
        #1;
        chk("wm_idle_stall", stall_0, 1);
        chk("wm_idle_cachewen", cwen_0, 0);
        step;
        mrr = 1; victim = 0; din = 0;
        #1;
        chk("wm_wb_memwen", mwen_0, 1);
        chk("wm_wb_memblockaddr", mba_0, 27'h155);
        chk("wm_wb_membyteen", mbe_0, 32'hFFFF_FFFF);
        chk("wm_wb_memdin", mdin_0, cache_line);
        chk("wm_wb_memren", mren_0, 0);
        chk("wm_wb_misscount", mcnt_0, 2);
        step;
        mrr = 0;
        #1;
        chk("wm_wb2_memwen", mwen_0, 1);
        mwd = 1;
        step;
        mwd = 0; mrr = 1;
        #1;
        chk("wm_mr_memren", mren_0, 1);
        chk("wm_mr_memwen", mwen_0, 0);
        chk("wm_mr_memblockaddr", mba_0, 2);
        step;
        mrr = 0;
        exp_merge = mem_line;
        exp_merge[2*32 +: 16] = 16'hCCDD;
        #1;
        chk("wm_fill_cachememwen", cmwen_0, 1);
        chk("wm_fill_cachedin", cdin_0, exp_merge);
        step;
        hit = 1; dirty = 0; din = 32'hAABB_CCDD;
        #1;
        chk("wm_replay_cachewen", cwen_0, 1);
        chk("wm_replay_stall", stall_0, 0);
        chk("wm_replay_bytesaccess", cba_0, 32'h0000_0300);
        step;
        wen = 0;

        // both strobes high is no request
        ren = 1; wen = 1; hit = 0;
        #1;
        chk("both_stall", stall_0, 0);
        chk("both_cacheren", cren_0, 0);
        chk("both_cachewen", cwen_0, 0);
        step;
        #1;
        chk("both_memren", mren_0, 0);
        chk("both_misscount", mcnt_0, 2);

        // reset in the middle of a write-back
        wen = 0; ren = 1; addr = 32'h24; hit = 0; dirty = 1; victim = 27'h0AA;
        step;
        #1;
        chk("rwb_memwen", mwen_0, 1);
        reset = 0; ren = 0; dirty = 0;
        step;
        #1;
        chk("rwb_after_memwen", mwen_0, 0);
        chk("rwb_after_misscount", mcnt_0, 0);
        chk("rwb_after_stall", stall_0, 0);
        chk("rwb_after_memren", mren_0, 0);
        reset = 1;
        step;
        #1;
        chk("rwb_released_cachememwen", cmwen_0, 0);
        chk("rwb_released_memwen", mwen_0, 0);

        // write-around instance: store bypasses the cache
        wen = 1; addr = 32'h48; din = 32'hAABB_CCDD; bsv = 4'b0011; hit = 0; dirty = 1;
        #1;
        chk("wa_idle_stall", stall_1, 1);
        step;
        #1;
        chk("wa_memwen", mwen_1, 1);
        chk("wa_memblockaddr", mba_1, 2);
        chk("wa_membyteen", mbe_1, 32'h0000_0300);
        chk("wa_memdin", mdin_1, {8{32'hAABB_CCDD}});
        chk("wa_memren", mren_1, 0);
        chk("wa_cachememwen", cmwen_1, 0);
        mwd = 1;
        step;
        mwd = 0;
        #1;
        chk("wa_resume_stall", stall_1, 0);
        chk("wa_resume_cachewen", cwen_1, 0);
        chk("wa_resume_memwen", mwen_1, 0);
        chk("wa_resume_cachememwen", cmwen_1, 0);
        chk("wa_resume_misscount", mcnt_1, 1);
        step;
        wen = 0; dirty = 0;
        #1;
        chk("wa_idle_after_stall", stall_1, 0);
        chk("wa_idle_after_misscount", mcnt_1, 1);

        // timeout instance: memory never answers the read
        ren = 1; addr = 32'h24; hit = 0;
        #1;
        chk("to_idle_stall", stall_1, 1);
        for (int i = 0; i < 4; i++) begin
            step;
            #1;
            chk($sformatf("to_mr%0d_memren", i + 1), mren_1, 1);
            chk($sformatf("to_mr%0d_memerror", i + 1), merr_1, 0);
        end
        step;
        #1;
        chk("to_idle_memerror", merr_1, 1);
        chk("to_idle_memren", mren_1, 0);
        chk("to_idle_restall", stall_1, 1);
        chk("to_idle_misscount", mcnt_1, 2);
        step;
        #1;
        chk("to_retry_memren", mren_1, 1);
        chk("to_retry_misscount", mcnt_1, 3);
        mrr = 1;
        step;
        mrr = 0;
        #1;
        chk("to_fill_cachememwen", cmwen_1, 1);
        chk("to_fill_cachedin", cdin_1, mem_line);
        step;
        hit = 1;
        #1;
        chk("to_replay_stall", stall_1, 0);
        chk("to_replay_cacheren", cren_1, 1);
        chk("to_sticky_memerror", merr_1, 1);
        ren = 0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
